// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_pkg
//  Description : Shared definitions for the integer write-back port arbiter.
//                Provides requester/port counts, the requester identity
//                enum, the write-back payload layout and an index-width
//                helper used to size source/port index fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int WB_N_REQ  = 4;
    localparam int WB_N_PORT = 2;
    localparam int WB_CNT_W  = 32;

    // Requester identity; the value is the requester's bit position.
    typedef enum logic [1:0] {
        WB_SRC_MISC = 2'd0,
        WB_SRC_ALU0 = 2'd1,
        WB_SRC_ALU1 = 2'd2,
        WB_SRC_MDU  = 2'd3
    } WbSrcE;

    // Opaque to the arbiter; only its total width matters here.
    typedef struct packed {
        logic [47:0] data;
        logic [4:0]  exc;
        logic [4:0]  rd;
        logic [5:0]  rob_idx;
    } WbPayloadSt;

    localparam int WB_PAYLOAD_W = $bits(WbPayloadSt);

    // Width of an index into n items; never narrower than one bit.
    function automatic int wb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : wb_port_arbiter_pkg
`default_nettype wire

// File: rtl/wb_port_arbiter_rr_multi_grant.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_rr_multi_grant
//  Description : Combinational round-robin multi-grant selector. Scans the
//                requesters starting at i_rr_ptr (wrapping) and grants the
//                first min(#free ports, #valid) valid ones. The k-th grant in
//                scan order is steered to the k-th free port in ascending
//                port order.
//  Ports       : i_valid     - per-requester eligible request
//                i_rr_ptr    - requester index where the scan starts
//                i_free      - per-port free mask
//                o_grant     - per-requester grant
//                o_port_sel  - per-requester destination port (valid if granted)
//                o_last      - index of the last requester granted
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter_rr_multi_grant #(
    parameter int N_REQ  = 4,
    parameter int N_PORT = 2,
    parameter int SRC_W  = 2,
    parameter int PORT_W = 1
) (
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [SRC_W-1:0]        i_rr_ptr,
    input  logic [N_PORT-1:0]       i_free,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ*PORT_W-1:0] o_port_sel,
    output logic [SRC_W-1:0]        o_last
);

    logic [N_PORT*PORT_W-1:0] w_free_list;  // free port indices, ascending, packed
    logic [SRC_W-1:0]         w_idx;

    always_comb begin
        int nf;
        int ng;
        w_free_list = '0;
        w_idx       = '0;
        o_grant     = '0;
        o_port_sel  = '0;
        o_last      = '0;
        nf          = 0;
        ng          = 0;

        // Compact the free ports into a list so grant k maps to list[k].
        for (int p = 0; p < N_PORT; p++) begin
            if (i_free[p]) begin
                w_free_list[nf*PORT_W +: PORT_W] = PORT_W'(p);
                nf = nf + 1;
            end
        end

        for (int k = 0; k < N_REQ; k++) begin
            w_idx = SRC_W'((int'(i_rr_ptr) + k) % N_REQ);
            if (i_valid[w_idx] && (ng < nf)) begin
                o_grant[w_idx] = 1'b1;
                o_port_sel[int'(w_idx)*PORT_W +: PORT_W] = w_free_list[ng*PORT_W +: PORT_W];
                o_last = w_idx;
                ng     = ng + 1;
            end
        end
    end

endmodule : wb_port_arbiter_rr_multi_grant
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares N_PORT register-file write-back ports among N_REQ
//                integer execute pipes. Grants are made round-robin each
//                cycle into per-port registered output stages with a
//                valid/ready handshake. Supports flush and a saturating
//                conflict counter.
//  Ports       : clk, a_rst_n        - clock, async active-low reset
//                flush_i             - discard all buffered write-backs
//                req_valid_i/_payload_i, req_ready_o - requester side
//                port_valid_o/_payload_o/_src_o, port_ready_i - port side
//                conflict_cnt_o      - cycles with an ungranted valid request
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int N_REQ     = WB_N_REQ,
    parameter int N_PORT    = WB_N_PORT,
    parameter int PAYLOAD_W = WB_PAYLOAD_W,
    parameter int CNT_W     = WB_CNT_W
) (
    input  logic                                clk,
    input  logic                                a_rst_n,
    input  logic                                flush_i,
    input  logic [N_REQ-1:0]                    req_valid_i,
    input  logic [N_REQ*PAYLOAD_W-1:0]          req_payload_i,
    output logic [N_REQ-1:0]                    req_ready_o,
    output logic [N_PORT-1:0]                   port_valid_o,
    output logic [N_PORT*PAYLOAD_W-1:0]         port_payload_o,
    output logic [N_PORT*wb_idx_w(N_REQ)-1:0]   port_src_o,
    input  logic [N_PORT-1:0]                   port_ready_i,
    output logic [CNT_W-1:0]                    conflict_cnt_o
);

    localparam int C_SRC_W  = wb_idx_w(N_REQ);
    localparam int C_PORT_W = wb_idx_w(N_PORT);

    logic [N_PORT-1:0]            r_port_valid;
    logic [N_PORT*PAYLOAD_W-1:0]  r_port_payload;
    logic [N_PORT*C_SRC_W-1:0]    r_port_src;
    logic [C_SRC_W-1:0]           r_rr_ptr;
    logic [CNT_W-1:0]             r_conflict_cnt;

    logic [N_PORT-1:0]            w_free;
    logic [N_REQ-1:0]             w_req_elig;
    logic [N_REQ-1:0]             w_grant;
    logic [N_REQ*C_PORT_W-1:0]    w_port_sel;
    logic [C_SRC_W-1:0]           w_last;
    logic [C_SRC_W-1:0]           w_ptr_next;
    logic                         w_conflict;
    logic [N_PORT-1:0]            w_load;
    logic [N_PORT*C_SRC_W-1:0]    w_load_src;
    logic [N_PORT*PAYLOAD_W-1:0]  w_load_payload;

    // A port that is draining this cycle can accept a new entry without a bubble.
    assign w_free = ~r_port_valid | port_ready_i;

    // Masking with the reset keeps req_ready_o low while reset is asserted,
    // and masking with flush blocks all grants in a flush cycle.
    assign w_req_elig = req_valid_i & {N_REQ{~flush_i & a_rst_n}};

    wb_port_arbiter_rr_multi_grant #(
        .N_REQ  (N_REQ),
        .N_PORT (N_PORT),
        .SRC_W  (C_SRC_W),
        .PORT_W (C_PORT_W)
    ) u_rr_multi_grant (
        .i_valid    (w_req_elig),
        .i_rr_ptr   (r_rr_ptr),
        .i_free     (w_free),
        .o_grant    (w_grant),
        .o_port_sel (w_port_sel),
        .o_last     (w_last)
    );

    assign req_ready_o = w_grant;

    assign w_ptr_next = (int'(w_last) == N_REQ - 1) ? '0 : C_SRC_W'(int'(w_last) + 1);
    assign w_conflict = (|(req_valid_i & ~w_grant)) & ~flush_i;

    // Invert the per-requester port select into a per-port load + source.
    for (genvar gp = 0; gp < N_PORT; gp++) begin : g_port
        logic               w_hit;
        logic [C_SRC_W-1:0] w_src;

        always_comb begin
            w_hit = 1'b0;
            w_src = '0;
            for (int r = 0; r < N_REQ; r++) begin
                if (w_grant[r] && (int'(w_port_sel[r*C_PORT_W +: C_PORT_W]) == gp)) begin
                    w_hit = 1'b1;
                    w_src = C_SRC_W'(r);
                end
            end
        end

        assign w_load[gp]                              = w_hit;
        assign w_load_src[gp*C_SRC_W +: C_SRC_W]       = w_src;
        assign w_load_payload[gp*PAYLOAD_W +: PAYLOAD_W] =
            req_payload_i[int'(w_src)*PAYLOAD_W +: PAYLOAD_W];
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_port_valid   <= '0;
            r_port_payload <= '0;
            r_port_src     <= '0;
            r_rr_ptr       <= '0;
            r_conflict_cnt <= '0;
        end else if (flush_i) begin
            r_port_valid <= '0;
        end else begin
            for (int p = 0; p < N_PORT; p++) begin
                if (w_load[p]) begin
                    r_port_valid[p]                        <= 1'b1;
                    r_port_payload[p*PAYLOAD_W +: PAYLOAD_W] <= w_load_payload[p*PAYLOAD_W +: PAYLOAD_W];
                    r_port_src[p*C_SRC_W +: C_SRC_W]       <= w_load_src[p*C_SRC_W +: C_SRC_W];
                end else if (port_ready_i[p]) begin
                    r_port_valid[p] <= 1'b0;
                end
            end
            if (|w_grant) begin
                r_rr_ptr <= w_ptr_next;
            end
            if (w_conflict && !(&r_conflict_cnt)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign port_valid_o   = r_port_valid;
    assign port_payload_o = r_port_payload;
    assign port_src_o     = r_port_src;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Self-checking bench for wb_port_arbiter. A queue-based
//                reference model predicts grants, port contents and the
//                conflict counter each cycle; directed scenarios add literal
//                expectations, followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int NR = 4;
    localparam int NP = 2;
    localparam int PW = 64;
    localparam int CW = 8;

    logic                clk = 1'b0;
    logic                a_rst_n;
    logic                flush_i;
    logic [NR-1:0]       req_valid_i;
    logic [NR*PW-1:0]    req_payload_i;
    logic [NR-1:0]       req_ready_o;
    logic [NP-1:0]       port_valid_o;
    logic [NP*PW-1:0]    port_payload_o;
    logic [NP*2-1:0]     port_src_o;
    logic [NP-1:0]       port_ready_i;
    logic [CW-1:0]       conflict_cnt_o;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .N_REQ     (NR),
        .N_PORT    (NP),
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .a_rst_n        (a_rst_n),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_payload_i  (req_payload_i),
        .req_ready_o    (req_ready_o),
        .port_valid_o   (port_valid_o),
        .port_payload_o (port_payload_o),
        .port_src_o     (port_src_o),
        .port_ready_i   (port_ready_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_val [NP];
    logic [PW-1:0] m_pay [NP];
    int            m_src [NP];
    int            m_ptr;
    int            m_cnt;
    logic [NR-1:0] cap_ready;
    logic [PW-1:0] saved_pay;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_val[p] = 1'b0;
            m_pay[p] = '0;
            m_src[p] = 0;
        end
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic compare_ports();
        for (int p = 0; p < NP; p++) begin
            chk("port_valid", 64'(port_valid_o[p]), 64'(m_val[p]));
            if (m_val[p]) begin
                chk("port_payload", port_payload_o[p*PW +: PW], m_pay[p]);
                chk("port_src", 64'(port_src_o[p*2 +: 2]), 64'(m_src[p]));
            end
        end
        chk("conflict_cnt", 64'(conflict_cnt_o), 64'(m_cnt));
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic [NP-1:0] rdy, input logic fl);
        req_valid_i  = v;
        port_ready_i = rdy;
        flush_i      = fl;
        for (int i = 0; i < NR; i++) req_payload_i[i*PW +: PW] = {$urandom, $urandom};
    endtask

    // One clock: check grants against the model, advance the model,
    // clock the DUT and check the registered outputs.
    task automatic cycle();
        int            freeq [$];
        int            reqq  [$];
        logic [NR-1:0] g;
        logic          nv [NP];
        logic [PW-1:0] npay [NP];
        int            nsrc [NP];
        int            p;
        int            r;
        int            last;
        #1;
        g = '0;
        last = -1;
        for (int i = 0; i < NP; i++) begin
            nv[i]   = m_val[i] && !port_ready_i[i];
            npay[i] = m_pay[i];
            nsrc[i] = m_src[i];
            if (!m_val[i] || port_ready_i[i]) freeq.push_back(i);
        end
        if (!flush_i) begin
            for (int k = 0; k < NR; k++) begin
                if (req_valid_i[(m_ptr + k) % NR]) reqq.push_back((m_ptr + k) % NR);
            end
        end
        while (freeq.size() > 0 && reqq.size() > 0) begin
            p = freeq.pop_front();
            r = reqq.pop_front();
            g[r]    = 1'b1;
            nv[p]   = 1'b1;
            npay[p] = req_payload_i[r*PW +: PW];
            nsrc[p] = r;
            last    = r;
        end
        if (flush_i) begin
            for (int i = 0; i < NP; i++) nv[i] = 1'b0;
        end
        cap_ready = req_ready_o;
        chk("req_ready", 64'(req_ready_o), 64'(g));
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            m_val[i] = nv[i];
            m_pay[i] = npay[i];
            m_src[i] = nsrc[i];
        end
        if (last >= 0) m_ptr = (last + 1) % NR;
        if (!flush_i && ((req_valid_i & ~g) != '0) && m_cnt != (1 << CW) - 1) m_cnt++;
        compare_ports();
    endtask

    initial begin
        a_rst_n       = 1'b0;
        flush_i       = 1'b0;
        req_valid_i   = '1;
        req_payload_i = '0;
        port_ready_i  = '1;
        model_reset();
        #12;
        // Reset values, with all requesters valid
        chk("rst_ready", 64'(req_ready_o), 64'h0);
        chk("rst_valid", 64'(port_valid_o), 64'h0);
        chk("rst_payload", port_payload_o[63:0], 64'h0);
        chk("rst_src", 64'(port_src_o), 64'h0);
        chk("rst_cnt", 64'(conflict_cnt_o), 64'h0);
        @(posedge clk);
        #1 a_rst_n = 1'b1;

        // All valid, both ports ready: {0,1}, {2,3}, {0,1}
        drive(4'b1111, 2'b11, 1'b0); cycle();
        chk("rr_c0_ready", 64'(cap_ready), 64'b0011);
        chk("rr_c0_src", 64'(port_src_o), 64'b0100);
        drive(4'b1111, 2'b11, 1'b0); cycle();
        chk("rr_c1_ready", 64'(cap_ready), 64'b1100);
        chk("rr_c1_src", 64'(port_src_o), 64'b1110);
        drive(4'b1111, 2'b11, 1'b0); cycle();
        chk("rr_c2_ready", 64'(cap_ready), 64'b0011);
        chk("rr_c2_cnt", 64'(conflict_cnt_o), 64'd3);

        // Port0 stalled with an entry, port1 empty, only req 3 valid
        drive(4'b0000, 2'b10, 1'b0); cycle();
        chk("stall_setup_valid", 64'(port_valid_o), 64'b01);
        saved_pay = port_payload_o[PW-1:0];
        drive(4'b1000, 2'b00, 1'b0); cycle();
        chk("req3_ready", 64'(cap_ready), 64'b1000);
        chk("req3_port1_src", 64'(port_src_o[3:2]), 64'd3);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 2'b00, 1'b0); cycle();
            chk("port0_hold", port_payload_o[PW-1:0], saved_pay);
        end

        // Both stalled, all valid for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 2'b00, 1'b0); cycle();
            chk("stalled_ready", 64'(cap_ready), 64'b0000);
        end
        chk("stalled_cnt", 64'(conflict_cnt_o), 64'd6);

        // Release port0 only: one grant, to requester at rr_ptr (0)
        drive(4'b1111, 2'b01, 1'b0); cycle();
        chk("release_ready", 64'(cap_ready), 64'b0001);

        // Flush with both ports full
        drive(4'b0010, 2'b00, 1'b1); cycle();
        chk("flush_ready", 64'(cap_ready), 64'b0000);
        chk("flush_valid", 64'(port_valid_o), 64'b00);
        chk("flush_cnt", 64'(conflict_cnt_o), 64'd7);
        drive(4'b1111, 2'b11, 1'b0); cycle();
        chk("post_flush_ready", 64'(cap_ready), 64'b0110);

        // Saturate the counter with stalled ports
        for (int i = 0; i < 300; i++) begin
            drive(4'b1111, 2'b00, 1'b0); cycle();
        end
        chk("cnt_saturated", 64'(conflict_cnt_o), 64'hFF);

        // Asynchronous reset mid-stream with ports full
        drive(4'b1111, 2'b00, 1'b0);
        a_rst_n = 1'b0;
        #2;
        chk("arst_valid", 64'(port_valid_o), 64'h0);
        chk("arst_payload0", port_payload_o[PW-1:0], 64'h0);
        chk("arst_payload1", port_payload_o[2*PW-1:PW], 64'h0);
        chk("arst_src", 64'(port_src_o), 64'h0);
        chk("arst_cnt", 64'(conflict_cnt_o), 64'h0);
        chk("arst_ready", 64'(req_ready_o), 64'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 a_rst_n = 1'b1;
        drive(4'b1111, 2'b11, 1'b0); cycle();
        chk("post_rst_ready", 64'(cap_ready), 64'b0011);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_port_arbiter
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares a small number of register-file write-back ports among the integer execute pipes: MISC, ALU0, ALU1 and MDU.
- Sits between the integer execution block's per-pipe write-back outputs and the write-back / wake-up network.
- Grants up to N_PORT producers per cycle in round-robin order and registers each grant into a per-port output stage with valid/ready handshake.
- Supports pipeline flush and exports a saturating conflict counter for performance tuning.

Parameters:
- N_REQ, 4, number of requesting pipes (index 0=MISC, 1=ALU0, 2=ALU1, 3=MDU).
- N_PORT, 2, number of write-back ports; N_PORT <= N_REQ.
- PAYLOAD_W, 64, width of the opaque write-back payload (rob index, rd, data, exception bits).
- CNT_W, 32, width of the conflict counter.

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  asynchronous reset, active low.
- flush_i  in  1  pipeline flush; discards all buffered write-backs.
- req_valid_i  in  N_REQ  per-pipe write-back valid.
- req_payload_i  in  N_REQ*PAYLOAD_W  per-pipe payload.
- req_ready_o  out  N_REQ  per-pipe grant; transfer occurs when valid & ready.
- port_valid_o  out  N_PORT  output port holds a write-back.
- port_payload_o  out  N_PORT*PAYLOAD_W  registered payload.
- port_src_o  out  N_PORT*clog2(N_REQ)  index of the requester that produced the entry.
- port_ready_i  in  N_PORT  consumer accepts the port entry.
- conflict_cnt_o  out  CNT_W  cycles in which at least one valid request was not granted.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on a_rst_n.
- Reset values:
  - port_valid_o=0, port_payload_o=0, port_src_o=0.
  - rr_ptr=0, conflict_cnt_o=0.
  - req_ready_o=0 while reset is asserted.
- Port free condition: port p is free when !port_valid_o[p] or port_ready_i[p].
- Grant selection (combinational):
  - F = number of free ports.
  - Scan requesters starting at rr_ptr, wrapping mod N_REQ, and grant the first min(F, #valid) valid ones.
  - The k-th grant in scan order loads the k-th free port, counting free ports in ascending index order.
- req_ready_o[i]=1 only if requester i is granted. It may depend on req_valid_i. Requesters must not make valid depend on ready.
- Latency: a payload granted in cycle t appears on port_valid_o/port_payload_o in cycle t+1.
- Hold rule: while port_valid_o[p] & !port_ready_i[p], port_payload_o[p] and port_src_o[p] stay stable.
- Port drain: a port that is drained this cycle and not reloaded clears its valid on the next cycle.
- Simultaneous drain and reload: a port that is both drained and loaded in the same cycle shows the new entry in the next cycle with no bubble.
- rr_ptr update:
  - If any grant is made, rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - Otherwise rr_ptr is unchanged.
- Fairness: any continuously valid requester is granted within ceil(N_REQ/N_PORT) cycles in which all ports are free.
- Flush:
  - In a cycle with flush_i=1, req_ready_o=0 (no grants).
  - Next cycle, all port_valid_o=0.
  - rr_ptr and conflict_cnt_o are unchanged.
  - Flush has priority over drain and load.
- conflict_cnt_o increments by 1 in every non-flush cycle with (req_valid_i & ~req_ready_o) != 0. It saturates at all-ones.
- No payload is ever duplicated or dropped except by flush.

Decomposition:
- Shared package (pipeline header):
  - WB_N_REQ and WB_N_PORT constants.
  - WbSrcE enum (MISC, ALU0, ALU1, MDU).
  - WbPayloadSt packed struct that determines PAYLOAD_W.
- One sub-module: rr_multi_grant. Purely combinational; inputs are valid, rr_ptr and free-port mask; outputs are the grant vector, a port-select per grant and the last-granted index.
- The top level holds the port registers, rr_ptr and the counter.

Test Plan:
- All 4 valid, both ports always ready, rr_ptr=0 -> cycle 0 grants {0,1} onto ports {0,1}; cycle 1 grants {2,3}; cycle 2 grants {0,1}; src on ports is 0,1 / 2,3 one cycle later.
- Only req 3 valid, port0 stalled with an entry (ready=0), port1 empty -> req 3 is granted into port1; port0 payload is unchanged across 5 stalled cycles.
- Both ports stalled and all 4 valid for 3 cycles -> req_ready_o=0000, conflict_cnt_o increases by 3.
- Then release port0 only -> exactly one grant, to the requester at rr_ptr.
- Both ports valid, flush_i=1 with req 1 valid -> req_ready_o=0; next cycle port_valid_o=00; rr_ptr unchanged; req 1 is granted on the following cycle.
- Load counter near saturation (force 0xFFFFFFFE) with 3 conflict cycles -> counter holds at 0xFFFFFFFF.
- Assert a_rst_n=0 mid-stream with ports full -> outputs and rr_ptr clear immediately, without waiting for a clock edge.
- Then after reset release with all 4 valid -> first grants are {0,1}.
